// File: rtl/dcache_pkg.sv
// Shared types and address-slicing helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LINES_DEF = 64;
  localparam int unsigned WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_e;

  // Word offset within a line; byte bits [1:0] are dropped.
  function automatic logic [ADDR_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned off_w,
                                                   input int unsigned idx_w);
    return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned off_w,
                                                 input int unsigned idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: combinational lookup plus one synchronous write port.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF,
  parameter int unsigned OFF_W = $clog2(WORDS),
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  lk_idx_i,
  input  logic [TAG_W-1:0]  lk_tag_i,
  input  logic [OFF_W-1:0]  lk_off_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] word_o,
  input  logic              we_i,
  input  logic              set_valid_i,
  input  logic              clr_valid_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  assign hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign word_o = data_q[lk_idx_i][lk_off_i];

  // A line is invalidated when its refill starts and only becomes valid on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_valid_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end else if (we_i && set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
    if (we_i && set_valid_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between MEM stage and data memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [OFF_W-1:0]  cur_off;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_word;
  logic              st_we, st_set_valid, st_clr_valid;
  logic [OFF_W-1:0]  st_off;
  logic [DATA_W-1:0] st_wdata;
  logic              stall_c;

  assign cur_off = OFF_W'(addr_offset(cpu_addr, OFF_W));
  assign cur_idx = IDX_W'(addr_index(cpu_addr, OFF_W, IDX_W));
  assign cur_tag = TAG_W'(addr_tag(cpu_addr, OFF_W, IDX_W));

  dcache_store #(
    .LINES(LINES), .WORDS(WORDS), .OFF_W(OFF_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk_idx_i    (cur_idx),
    .lk_tag_i    (cur_tag),
    .lk_off_i    (cur_off),
    .hit_o       (lk_hit),
    .word_o      (lk_word),
    .we_i        (st_we),
    .set_valid_i (st_set_valid),
    .clr_valid_i (st_clr_valid),
    .wr_idx_i    (cur_idx),
    .wr_off_i    (st_off),
    .wr_tag_i    (cur_tag),
    .wr_data_i   (st_wdata)
  );

  // Next-state, memory-port and combinational CPU-side outputs; the CPU holds its address while stalled.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    st_we        = 1'b0;
    st_set_valid = 1'b0;
    st_clr_valid = 1'b0;
    st_off       = cnt_q;
    st_wdata     = mem_rdata;
    stall_c      = 1'b0;
    cpu_rdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          stall_c     = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = {2'b00, cpu_addr[ADDR_W-1:2]};
          mem_wdata_d = cpu_wdata;
          state_d     = WRITE;
        end else if (cpu_rd) begin
          if (lk_hit) begin
            cpu_rdata = lk_word;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            stall_c      = 1'b1;
            miss_cnt_d   = miss_cnt_q + 32'd1;
            cnt_d        = '0;
            mem_rd_d     = 1'b1;
            mem_addr_d   = ADDR_W'({cur_tag, cur_idx, OFF_W'(0)});
            st_clr_valid = 1'b1;
            state_d      = FILL;
          end
        end
      end
      FILL: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          st_we = 1'b1;
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) begin
            st_set_valid = 1'b1;
            mem_rd_d     = 1'b0;
            state_d      = IDLE;
          end else begin
            mem_addr_d = ADDR_W'({cur_tag, cur_idx, cnt_q + OFF_W'(1)});
          end
        end
      end
      WRITE: begin
        stall_c = !mem_ready;
        if (mem_ready) begin
          mem_wr_d = 1'b0;
          state_d  = IDLE;
          if (lk_hit) begin
            st_we    = 1'b1;
            st_off   = cur_off;
            st_wdata = cpu_wdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Stall is forced low while reset is held, even if a load is still presented.
  assign cpu_stall = stall_c & rst_n;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores against a latency-2 memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mtxn_t;

  int          checks = 0;
  int          errors = 0;
  int          txn_cnt = 0;
  int          lat_cnt = 0;
  int          mem_lat = 2;
  int          exp_hit = 0;
  int          exp_miss = 0;
  logic [31:0] exp_rd [$];
  mtxn_t       exp_mem [$];
  mtxn_t       m_e;
  logic [31:0] mem_arr [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a;
  endfunction

  // Memory model: each request sees ready on its second cycle; handshakes are checked against the queue.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n || !(mem_rd || mem_wr)) begin
      mem_ready = 1'b0;
      lat_cnt   = 0;
    end else begin
      if (mem_ready) lat_cnt = 0;
      lat_cnt++;
      mem_ready = 1'b0;
      if (lat_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        txn_cnt++;
        if (exp_mem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_txn: unexpected rd=%0b wr=%0b at 0x%08h", mem_rd, mem_wr, mem_addr);
        end else begin
          m_e = exp_mem.pop_front();
          chk("mem_kind", 32'(mem_wr), 32'(m_e.wr));
          chk("mem_addr", mem_addr, m_e.addr);
          if (m_e.wr) chk("mem_wdata", mem_wdata, m_e.data);
        end
        if (mem_wr) mem_arr[mem_addr] = mem_wdata;
        else mem_rdata = mem_read(mem_addr);
      end
    end
  end

  // CPU-side monitor: a load completes on any cycle with cpu_rd high and no stall.
  always @(negedge clk) begin
    if (rst_n && cpu_rd && !cpu_wr && !cpu_stall) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_rdata: unexpected load completion, got 0x%08h", cpu_rdata);
      end else begin
        chk("cpu_rdata", cpu_rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic wait_release(output int stalls);
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
    end
    if (stalls >= 200) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: stall never released after %0d cycles", stalls);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hit));
    chk({tag, "_miss_cnt"}, miss_cnt, 32'(exp_miss));
  endtask

  task automatic cpu_load(input logic [31:0] a, input logic [31:0] exp_data, input bit miss);
    int stalls;
    int t0;
    t0 = txn_cnt;
    exp_rd.push_back(exp_data);
    if (miss) begin
      for (int w = 0; w < 4; w++) exp_mem.push_back('{1'b0, ((a >> 2) & ~32'h3) + 32'(w), 32'h0});
      exp_miss++;
    end
    exp_hit++;
    cpu_addr = a;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
    wait_release(stalls);
    cpu_rd = 1'b0;
    chk("load_stall", 32'(stalls), miss ? 32'(4 * mem_lat + 1) : 32'd0);
    chk("load_traffic", 32'(txn_cnt - t0), miss ? 32'd4 : 32'd0);
    check_counters("load");
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input bit also_rd);
    int stalls;
    int t0;
    t0 = txn_cnt;
    exp_mem.push_back('{1'b1, a >> 2, d});
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_rd    = also_rd;
    wait_release(stalls);
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    chk("store_stall", 32'(stalls), 32'(mem_lat));
    chk("store_traffic", 32'(txn_cnt - t0), 32'd1);
    check_counters("store");
  endtask

  initial begin
    #1;
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_counters("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold fill, then hits on the same line
    cpu_load(32'h0000_0040, 32'h0000_0010, 1'b1);
    cpu_load(32'h0000_0044, 32'h0000_0011, 1'b0);
    cpu_load(32'h0000_0048, 32'h0000_0012, 1'b0);

    // Conflict on index 4 evicts tag 0; reloading 0x40 misses again
    cpu_load(32'h0000_0440, 32'h0000_0110, 1'b1);
    cpu_load(32'h0000_0040, 32'h0000_0010, 1'b1);

    // Store hit updates line and memory
    cpu_store(32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
    cpu_load(32'h0000_0044, 32'hDEAD_BEEF, 1'b0);

    // Store miss: memory only, the later load fills the written value
    cpu_store(32'h0000_0800, 32'h1234_5678, 1'b0);
    cpu_load(32'h0000_0800, 32'h1234_5678, 1'b1);

    // Both strobes high behaves as a store
    cpu_store(32'h0000_0048, 32'hCAFE_F00D, 1'b1);
    cpu_load(32'h0000_0048, 32'hCAFE_F00D, 1'b0);

    // Reset in the middle of a refill of 0x440
    begin
      int t0;
      t0 = txn_cnt;
      exp_mem.push_back('{1'b0, 32'h0000_0110, 32'h0});
      exp_mem.push_back('{1'b0, 32'h0000_0111, 32'h0});
      cpu_addr = 32'h0000_0440;
      cpu_rd   = 1'b1;
      for (int i = 0; i < 100 && txn_cnt < t0 + 2; i++) @(posedge clk);
      chk("midfill_words", 32'(txn_cnt - t0), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midfill_mem_rd", 32'(mem_rd), 32'd0);
      chk("midfill_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("midfill_mem_addr", mem_addr, 32'd0);
      exp_hit  = 0;
      exp_miss = 0;
      check_counters("midfill");
      cpu_rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end

    cpu_load(32'h0000_0040, 32'h0000_0010, 1'b1);
    cpu_load(32'h0000_0044, 32'hDEAD_BEEF, 1'b0);

    repeat (3) @(posedge clk);
    chk("exp_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
